// File: rtl/key_event_gen.sv
// ---------------------------------------------------------------------------
// key_event_gen
//
// Turns four debounced, active-high switch levels into single-cycle event
// pulses for the clock's mode blocks: press, short release, long-press,
// auto-repeat and release.  Each key runs its own four-state FSM plus a hold
// counter.  The counter advances only on en_tick, so hold timing does not
// depend on the system clock rate.
//
// Parameters:
//   LONG_TICKS   - ticks of continuous hold before key_long (2..2^CNT_W-1)
//   REPEAT_TICKS - ticks between key_rep pulses once long (1..2^CNT_W-1)
//   CNT_W        - width of each per-key hold counter
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous reset, active low
//   en_tick      - one-clk-wide hold-timing strobe
//   key_in[3:0]  - debounced switch levels, 1 = pressed
//   key_press    - pulse: press accepted
//   key_short    - pulse: released before long-press
//   key_long     - pulse: hold reached LONG_TICKS
//   key_rep      - pulse: every REPEAT_TICKS while in long hold
//   key_release  - pulse: any release of an accepted press
//   key_held     - level: key is in PRESSED or LONG
// All outputs are registered.
// ---------------------------------------------------------------------------
module key_event_gen #(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_tick,
    input  logic [3:0] key_in,
    output logic [3:0] key_press,
    output logic [3:0] key_short,
    output logic [3:0] key_long,
    output logic [3:0] key_rep,
    output logic [3:0] key_release,
    output logic [3:0] key_held
);

    typedef enum logic [1:0] {
        DISARM  = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        LONG    = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_TICKS);

    state_e           state_q [4];
    state_e           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];

    logic [3:0] press_q,   press_d;
    logic [3:0] short_q,   short_d;
    logic [3:0] long_q,    long_d;
    logic [3:0] rep_q,     rep_d;
    logic [3:0] release_q, release_d;
    logic [3:0] held_q,    held_d;

    // Next-state and next-output logic for the four independent key FSMs.
    // A release always takes priority over a tick arriving in the same cycle,
    // so a key let go exactly on the long/repeat boundary never fires those.
    always_comb begin
        press_d   = '0;
        short_d   = '0;
        long_d    = '0;
        rep_d     = '0;
        release_d = '0;
        held_d    = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                // A key found pressed out of reset must be let go first.
                DISARM: begin
                    if (!key_in[i]) begin
                        state_d[i] = IDLE;
                    end
                end
                IDLE: begin
                    if (key_in[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                        press_d[i] = 1'b1;
                    end
                end
                PRESSED: begin
                    if (!key_in[i]) begin
                        state_d[i]   = IDLE;
                        cnt_d[i]     = '0;
                        short_d[i]   = 1'b1;
                        release_d[i] = 1'b1;
                    end else if (en_tick) begin
                        if ((cnt_q[i] + 1'b1) == LONG_C) begin
                            state_d[i] = LONG;
                            cnt_d[i]   = '0;
                            long_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
                LONG: begin
                    if (!key_in[i]) begin
                        state_d[i]   = IDLE;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                    end else if (en_tick) begin
                        if ((cnt_q[i] + 1'b1) == REP_C) begin
                            cnt_d[i] = '0;
                            rep_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            endcase
            // Held is registered from the next state so it rises with
            // key_press and falls with key_release.
            held_d[i] = (state_d[i] == PRESSED) || (state_d[i] == LONG);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= DISARM;
                cnt_q[i]   <= '0;
            end
            press_q   <= '0;
            short_q   <= '0;
            long_q    <= '0;
            rep_q     <= '0;
            release_q <= '0;
            held_q    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            press_q   <= press_d;
            short_q   <= short_d;
            long_q    <= long_d;
            rep_q     <= rep_d;
            release_q <= release_d;
            held_q    <= held_d;
        end
    end

    assign key_press   = press_q;
    assign key_short   = short_q;
    assign key_long    = long_q;
    assign key_rep     = rep_q;
    assign key_release = release_q;
    assign key_held    = held_q;

endmodule
